// File: rtl/systolic_feeder_pkg.sv
// systolic_pkg: FSM encoding, write-select codes and stream sizing shared by the feeder.
package systolic_pkg;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;
    // A stream of 3*DIM-2 beats lets the last products ripple to the far corner.
    function automatic int stream_len(input int dim);
        return 3 * dim - 2;
    endfunction
    function automatic int cnt_w(input int dim);
        return $clog2(3 * dim - 2);
    endfunction
endpackage

// File: rtl/systolic_feeder_skew_lane.sv
// skew_lane: picks element t-LANE of a stored row/column, zero outside the DIM-wide window.
module skew_lane import systolic_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM = 4,
    parameter int LANE = 0,
    parameter int CW = cnt_w(DIM)
) (
    input  logic [CW-1:0]             t,
    input  logic [DIM*DATA_WIDTH-1:0] vec,
    output logic [DATA_WIDTH-1:0]     elem
);
    localparam int IW = $clog2(DIM);
    localparam logic [CW:0] LANE_W = (CW+1)'(LANE);
    localparam logic [CW:0] DIM_W = (CW+1)'(DIM);
    logic [CW:0] k;
    assign k = {1'b0, t} - LANE_W;
    assign elem = ({1'b0, t} >= LANE_W && k < DIM_W) ? vec[k[IW-1:0]*DATA_WIDTH +: DATA_WIDTH] : '0;
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: holds A and B, streams them diagonally skewed into the PE array edge.
module systolic_feeder import systolic_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wr_en_i,
    input  logic                      wr_sel_i,
    input  logic [$clog2(DIM)-1:0]    wr_row_i,
    input  logic [DIM*DATA_WIDTH-1:0] wr_data_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      valid_o,
    output logic [DIM*DATA_WIDTH-1:0] left_o,
    output logic [DIM*DATA_WIDTH-1:0] up_o,
    output logic                      done_o
);
    localparam int LEN = stream_len(DIM);
    localparam int CW = cnt_w(DIM);
    localparam int RW = $clog2(DIM);
    localparam int W = DIM * DATA_WIDTH;
    logic [1:0] state;
    logic [CW-1:0] t, nt;
    logic last, run_nxt, wr_ok;
    logic [W-1:0] a[DIM], b[DIM], a_nxt[DIM], b_nxt[DIM], b_col[DIM];
    logic [W-1:0] left_nxt, up_nxt;
    assign wr_ok = state == IDLE && wr_en_i;
    assign last = t == CW'(LEN - 1);
    assign nt = state == IDLE ? '0 : t + 1'b1;
    assign run_nxt = (state == IDLE && start_i) || (state == STREAM && !last);
    // Lanes see the post-write storage so a write coinciding with start is streamed.
    for (genvar i = 0; i < DIM; i++) begin : g_row
        assign a_nxt[i] = (wr_ok && wr_sel_i == SEL_A && wr_row_i == RW'(i)) ? wr_data_i : a[i];
        assign b_nxt[i] = (wr_ok && wr_sel_i == SEL_B && wr_row_i == RW'(i)) ? wr_data_i : b[i];
        for (genvar j = 0; j < DIM; j++) begin : g_col
            assign b_col[j][i*DATA_WIDTH +: DATA_WIDTH] = b_nxt[i][j*DATA_WIDTH +: DATA_WIDTH];
        end
        skew_lane #(.DATA_WIDTH(DATA_WIDTH), .DIM(DIM), .LANE(i), .CW(CW)) u_left (
            .t(nt), .vec(a_nxt[i]), .elem(left_nxt[i*DATA_WIDTH +: DATA_WIDTH])
        );
        skew_lane #(.DATA_WIDTH(DATA_WIDTH), .DIM(DIM), .LANE(i), .CW(CW)) u_up (
            .t(nt), .vec(b_col[i]), .elem(up_nxt[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a <= '{default: '0};
            b <= '{default: '0};
        end else begin
            a <= a_nxt;
            b <= b_nxt;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            t <= '0;
            left_o <= '0;
            up_o <= '0;
        end else begin
            state <= state == IDLE ? (start_i ? STREAM : IDLE) : state == STREAM ? (last ? DONE : STREAM) : IDLE;
            t <= run_nxt ? nt : '0;
            left_o <= run_nxt ? left_nxt : '0;
            up_o <= run_nxt ? up_nxt : '0;
        end
    end
    assign valid_o = state == STREAM;
    assign busy_o = state != IDLE;
    assign done_o = state == DONE;
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: scoreboard bench for the skewed matrix feeder with a small PE array model.
module tb_systolic_feeder;
    localparam int DW = 32, D = 4, L = 10, W = D * DW;
    logic clk = 0, rst = 1, wr_en = 0, wr_sel = 0, start = 0, pe_clr = 0;
    logic [1:0] wr_row = '0;
    logic [W-1:0] wr_data = '0, left, up;
    logic busy, valid, done;
    typedef struct packed {logic [W-1:0] l; logic [W-1:0] u;} beat_t;
    beat_t exp_q[$];
    logic [DW-1:0] ma[D][D], mb[D][D], h[D][D], v[D][D], acc[D][D];
    logic [W-1:0] cap_l[L], cap_u[L];
    int bi = 0, n_cmp = 0, n_bad = 0;

    systolic_feeder #(.DATA_WIDTH(DW), .DIM(D)) dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_row_i(wr_row),
        .wr_data_i(wr_data), .start_i(start), .busy_o(busy), .valid_o(valid),
        .left_o(left), .up_o(up), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t model_beat(input int t);
        beat_t b = '0;
        for (int i = 0; i < D; i++)
            if (t - i >= 0 && t - i < D) begin
                b.l[i*DW +: DW] = ma[i][t-i];
                b.u[i*DW +: DW] = mb[t-i][i];
            end
        return b;
    endfunction

    task automatic model_write(input logic sel, input int row, input logic [W-1:0] data);
        if (row < D)
            for (int c = 0; c < D; c++)
                if (sel) mb[row][c] = data[c*DW +: DW];
                else ma[row][c] = data[c*DW +: DW];
    endtask

    // Monitor: every presented beat is popped and compared against the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got valid with left %0h, expected no beat", left);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("beat%0d left", bi), left, e.l);
                check($sformatf("beat%0d up", bi), up, e.u);
            end
            if (bi < L) begin
                cap_l[bi] = left;
                cap_u[bi] = up;
            end
            bi++;
        end else bi = 0;
    end

    function automatic logic [DW-1:0] pe_l(input int i, input int j);
        if (j == 0) return left[i*DW +: DW];
        return h[i][j-1];
    endfunction
    function automatic logic [DW-1:0] pe_u(input int i, input int j);
        if (i == 0) return up[j*DW +: DW];
        return v[i-1][j];
    endfunction

    always @(posedge clk)
        for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++) begin
                h[i][j] <= pe_clr ? '0 : pe_l(i, j);
                v[i][j] <= pe_clr ? '0 : pe_u(i, j);
                acc[i][j] <= pe_clr ? '0 : acc[i][j] + pe_l(i, j) * pe_u(i, j);
            end

    task automatic write_row(input logic sel, input int row, input logic [W-1:0] data);
        @(negedge clk);
        wr_en = 1; wr_sel = sel; wr_row = row[1:0]; wr_data = data;
        model_write(sel, row, data);
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic run_stream(input string tag, input int poke, input logic wr_too, input logic [W-1:0] wdata);
        int vc = 0, guard = 0;
        @(negedge clk);
        start = 1;
        if (wr_too) begin
            wr_en = 1; wr_sel = 0; wr_row = 0; wr_data = wdata;
            model_write(0, 0, wdata);
        end
        for (int t = 0; t < L; t++) exp_q.push_back(model_beat(t));
        @(negedge clk);
        start = 0; wr_en = 0;
        while (valid && guard < 4 * L) begin
            if (vc == poke) begin
                start = 1; wr_en = 1; wr_sel = 0; wr_row = 0; wr_data = {W{1'b1}};
            end else begin
                start = 0; wr_en = 0;
            end
            vc++; guard++;
            @(negedge clk);
        end
        start = 0; wr_en = 0;
        check({tag, " valid_cycles"}, vc, L);
        check({tag, " done_after_last"}, done, 1);
        check({tag, " busy_in_done"}, busy, 1);
        @(negedge clk);
        check({tag, " done_one_cycle"}, done, 0);
        check({tag, " busy_drop"}, busy, 0);
        check({tag, " valid_idle"}, valid, 0);
        check({tag, " queue_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++) begin
                ma[i][j] = '0;
                mb[i][j] = '0;
            end
        #12;
        check("reset left", left, 0);
        check("reset up", up, 0);
        check("reset flags", {valid, busy, done}, 0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < D; i++) begin
            write_row(0, i, {32'(16*i+3), 32'(16*i+2), 32'(16*i+1), 32'(16*i)});
            write_row(1, i, {32'(256+16*i+3), 32'(256+16*i+2), 32'(256+16*i+1), 32'(256+16*i)});
        end
        run_stream("skew", -1, 0, '0);
        check("skew beat0 left", cap_l[0], 0);
        check("skew beat0 up", cap_u[0], 256);
        check("skew beat3 left3", cap_l[3][127:96], 48);
        check("skew beat3 up3", cap_u[3][127:96], 259);
        check("skew beat6 left", cap_l[6], {32'd51, 96'd0});
        check("skew beat6 up", cap_u[6], {32'd307, 96'd0});
        check("skew beat9 left", cap_l[9], 0);
        check("skew beat9 up", cap_u[9], 0);

        run_stream("ignore", 5, 0, '0);
        repeat (3) @(negedge clk);
        check("no_restart valid", valid, 0);
        check("no_restart busy", busy, 0);
        run_stream("restream", -1, 0, '0);
        check("restream beat0 left", cap_l[0], 0);
        check("restream beat6 left", cap_l[6], {32'd51, 96'd0});

        @(negedge clk);
        start = 1;
        for (int t = 0; t < L; t++) exp_q.push_back(model_beat(t));
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        #2 rst = 1;
        #1;
        check("midreset left", left, 0);
        check("midreset up", up, 0);
        check("midreset flags", {valid, busy, done}, 0);
        exp_q.delete();
        for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++) begin
                ma[i][j] = '0;
                mb[i][j] = '0;
            end
        @(negedge clk);
        rst = 0;
        run_stream("after_reset", -1, 0, '0);
        check("after_reset beat3 up", cap_u[3], 0);
        check("after_reset beat6 left", cap_l[6], 0);

        run_stream("wr_start", -1, 1, {32'd4, 32'd3, 32'd2, 32'd1});
        check("wr_start beat0 left0", cap_l[0][31:0], 1);
        check("wr_start beat3 left0", cap_l[3][31:0], 4);

        for (int i = 0; i < D; i++) begin
            write_row(0, i, W'(1) << (i * DW));
            write_row(1, i, {32'(i+4), 32'(i+3), 32'(i+2), 32'(i+1)});
        end
        @(negedge clk);
        pe_clr = 1;
        @(negedge clk);
        pe_clr = 0;
        run_stream("e2e", -1, 0, '0);
        repeat (2 * D) @(negedge clk);
        for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++)
                check($sformatf("e2e pe(%0d,%0d)", i, j), acc[i][j], i + j + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
